// File: rtl/vmem_write_arbiter_if.sv
// Handshake and BRAM write-port bundle for vmem_write_arbiter.
// master = requester/memory side, slave = the arbiter.
interface vmem_write_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MASK       = 1,
  parameter int MEM_DEPTH  = 10,
  parameter int MVL        = 32,
  parameter int MAX_STRIDE = 16
);
  localparam int SW  = $clog2(MAX_STRIDE + 1) + 1;
  localparam int VLW = $clog2(MVL + 1) + 1;
  localparam int EW  = DATA_WIDTH + MASK;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*MEM_DEPTH-1:0] req_base;
  logic [NUM_REQ*SW-1:0]        req_stride;
  logic [NUM_REQ*VLW-1:0]       req_vl;
  logic [NUM_REQ-1:0]           data_valid;
  logic [NUM_REQ*EW-1:0]        data_in;
  logic [NUM_REQ-1:0]           data_ready;
  logic [MEM_DEPTH-1:0]         mem_addr_write;
  logic [DATA_WIDTH-1:0]        mem_data;
  logic                         mem_w_en;
  logic                         busy;
  logic [NUM_REQ-1:0]           done;

  modport master (
    output req_valid, req_base, req_stride, req_vl, data_valid, data_in,
    input  req_ready, data_ready, mem_addr_write, mem_data, mem_w_en, busy, done
  );
  modport slave (
    input  req_valid, req_base, req_stride, req_vl, data_valid, data_in,
    output req_ready, data_ready, mem_addr_write, mem_data, mem_w_en, busy, done
  );
endinterface

// File: rtl/vmem_write_arbiter.sv
// Round-robin arbiter sharing one BRAM write port among NUM_REQ strided vector store streams.
// Define VMEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins grant selection instead.
module vmem_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MASK       = 1,
  parameter int MEM_DEPTH  = 10,
  parameter int MVL        = 32,
  parameter int MAX_STRIDE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  vmem_write_arbiter_if.slave       bus,
  output logic [1:0]                dbg_state
);
  localparam int SW  = $clog2(MAX_STRIDE + 1) + 1;
  localparam int VLW = $clog2(MVL + 1) + 1;
  localparam int EW  = DATA_WIDTH + MASK;
  localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2} state_t;

  state_t               state, state_next;
  logic [GW-1:0]        gnt, pick;
  logic                 pick_found;
  logic [MEM_DEPTH-1:0] addr, pick_base;
  logic [SW-1:0]        stride_r, pick_stride, raw_stride;
  logic [VLW-1:0]       vl_r, cnt, pick_vl, raw_vl;
  logic [EW-1:0]        elem;
  logic                 consume, last_elem;
`ifndef VMEM_ARB_FIXED_PRIO_EN
  logic [GW-1:0]        last;
`endif

  assign dbg_state = state;

  // Grant search: round-robin starts just after the last served requester.
  always_comb begin
    logic [GW-1:0] idx;
    pick_found = 1'b0;
    pick       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef VMEM_ARB_FIXED_PRIO_EN
      idx = GW'(i);
`else
      idx = GW'((int'(last) + 1 + i) % NUM_REQ);
`endif
      if (!pick_found && bus.req_valid[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  always_comb begin
    pick_base   = '0;
    raw_stride  = '0;
    raw_vl      = '0;
    elem        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) begin
        pick_base  = bus.req_base[i*MEM_DEPTH +: MEM_DEPTH];
        raw_stride = bus.req_stride[i*SW +: SW];
        raw_vl     = bus.req_vl[i*VLW +: VLW];
      end
      if (gnt == GW'(i)) elem = bus.data_in[i*EW +: EW];
    end
    pick_stride = (raw_stride > SW'(MAX_STRIDE)) ? SW'(MAX_STRIDE) : raw_stride;
    pick_vl     = (raw_vl > VLW'(MVL)) ? VLW'(MVL) : raw_vl;
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready is a combinational function of state, grant and (for req_ready) req_valid.
  always_comb begin
    state_next     = state;
    bus.req_ready  = '0;
    bus.data_ready = '0;
    consume        = 1'b0;
    last_elem      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          bus.req_ready[pick] = 1'b1;
          state_next = (pick_vl == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        bus.data_ready[gnt] = 1'b1;
        consume   = bus.data_valid[gnt];
        last_elem = (cnt == vl_r - VLW'(1));
        if (consume && last_elem) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (rst) begin
      bus.req_ready  = '0;
      bus.data_ready = '0;
      consume        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      gnt                <= '0;
      addr               <= '0;
      stride_r           <= '0;
      vl_r               <= '0;
      cnt                <= '0;
      bus.mem_addr_write <= '0;
      bus.mem_data       <= '0;
      bus.mem_w_en       <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= '0;
`ifndef VMEM_ARB_FIXED_PRIO_EN
      last               <= GW'(NUM_REQ - 1);
`endif
    end else begin
      state        <= state_next;
      bus.busy     <= (state_next != IDLE);
      bus.mem_w_en <= 1'b0;
      bus.done     <= '0;
      if (state == IDLE && pick_found) begin
        gnt      <= pick;
        addr     <= pick_base;
        stride_r <= pick_stride;
        vl_r     <= pick_vl;
        cnt      <= '0;
        if (pick_vl == '0) bus.done[pick] <= 1'b1;
      end
      // Masked-off elements still advance the address and count.
      if (consume) begin
        bus.mem_addr_write <= addr;
        bus.mem_data       <= elem[DATA_WIDTH-1:0];
        bus.mem_w_en       <= elem[EW-1];
        addr               <= addr + MEM_DEPTH'(stride_r);
        cnt                <= cnt + VLW'(1);
        if (last_elem) bus.done[gnt] <= 1'b1;
      end
`ifndef VMEM_ARB_FIXED_PRIO_EN
      if (state == DONE) last <= gnt;
`endif
    end
  end
endmodule

// File: tb/tb_vmem_write_arbiter.sv
// Directed and randomized bench for vmem_write_arbiter; expected writes come from a
// closed-form address model (base + k*stride mod 2^MEM_DEPTH) held in a queue.
module tb_vmem_write_arbiter;
  localparam int NR   = 2;
  localparam int DW   = 32;
  localparam int MD   = 10;
  localparam int SW   = 6;
  localparam int VLW  = 7;
  localparam int EW   = 33;
  localparam int MAXS = 16;
  localparam int MVLV = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  vmem_write_arbiter_if bus ();

  vmem_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [MD+DW-1:0] exp_q[$];
  int wr_cyc_q[$];
  int wr_cnt = 0, done_cnt = 0, last_wr_cyc = -1;
  int grant_cyc, done_cyc;

  logic [DW-1:0] el_data[64];
  bit            el_mask[64];
  int            el_stall[64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [MD+DW-1:0] e;
    if (bus.done != '0) done_cnt++;
    if (bus.mem_w_en === 1'b1) begin
      wr_cnt++;
      wr_cyc_q.push_back(cyc);
      last_wr_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL unexpected_write got=%0h_%0h exp=none", bus.mem_addr_write, bus.mem_data);
      end else begin
        e = exp_q.pop_front();
        assert ({bus.mem_addr_write, bus.mem_data} === e) else begin
          bad++;
          $error("FAIL write got=%0h_%0h exp=%0h_%0h", bus.mem_addr_write, bus.mem_data,
                 e[MD+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill(input int n, input int stall_max, input bit rand_mask);
    for (int k = 0; k < n; k++) begin
      el_data[k]  = $urandom;
      el_mask[k]  = rand_mask ? 1'($urandom_range(0, 1)) : 1'b1;
      el_stall[k] = $urandom_range(0, stall_max);
    end
  endtask

  task automatic issue(input int r, input int base, input int stride, input int vl, output bit ok);
    @(posedge clk); #1;
    bus.req_base[r*MD +: MD]    = MD'(base);
    bus.req_stride[r*SW +: SW]  = SW'(stride);
    bus.req_vl[r*VLW +: VLW]    = VLW'(vl);
    bus.req_valid[r]            = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        ok = 1'b1;
        grant_cyc = cyc;
        chk("grant_onehot", bus.req_ready, 64'(1 << r));
      end
    end
    if (!ok) chk("grant_timeout", 0, 1);
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic feed(input int r, input int n);
    int o;
    bit got;
    o = (r + 1) % NR;
    for (int k = 0; k < n; k++) begin
      bus.data_valid[r] = 1'b0;
      bus.data_valid[o] = 1'b1;
      bus.data_in[o*EW +: EW] = {1'b1, 32'($urandom)};
      repeat (el_stall[k]) begin @(posedge clk); #1; end
      bus.data_in[r*EW +: EW] = {el_mask[k], el_data[k]};
      bus.data_valid[r] = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        if (bus.data_ready[r]) got = 1'b1;
        @(posedge clk); #1;
      end
      if (!got) chk("data_timeout", 0, 1);
    end
    bus.data_valid = '0;
  endtask

  task automatic wait_done(input int r);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        got = 1'b1;
        done_cyc = cyc;
        chk("done_onehot", bus.done, 64'(1 << r));
        chk("busy_in_done", bus.busy, 1);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  // Model: element k lands at (base + k*min(stride,16)) mod 1024; only min(vl,32) elements.
  task automatic run_stream(input int r, input int base, input int stride, input int vl);
    int es, ev, nw, w0;
    bit ok;
    es = (stride > MAXS) ? MAXS : stride;
    ev = (vl > MVLV) ? MVLV : vl;
    nw = 0;
    for (int k = 0; k < ev; k++) begin
      if (el_mask[k]) begin
        exp_q.push_back({MD'((base + k * es) % (1 << MD)), el_data[k]});
        nw++;
      end
    end
    w0 = wr_cnt;
    wr_cyc_q.delete();
    issue(r, base, stride, vl, ok);
    if (ok) begin
      feed(r, ev);
      wait_done(r);
    end
    @(negedge clk);
    chk("busy_after_done", bus.busy, 0);
    chk("write_count", wr_cnt - w0, nw);
    chk("exp_q_drained", exp_q.size(), 0);
    if (ok && ev > 0 && el_mask[ev-1]) chk("done_with_last_write", last_wr_cyc, done_cyc);
    if (ok && ev == 0) chk("zero_vl_done_latency", done_cyc, grant_cyc + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NR-1:0] gq[$];
    int dc0, r, base, stride, vl;
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_base   = '0;
    bus.req_stride = '0;
    bus.req_vl     = '0;
    bus.data_valid = '0;
    bus.data_in    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_w_en", bus.mem_w_en, 0);
    chk("rst_mem_addr", bus.mem_addr_write, 0);
    chk("rst_mem_data", bus.mem_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_data_ready", bus.data_ready, 0);
    chk("rst_state", dbg_state, 0);

    // Arbitration: both requesters hold zero-length requests from reset.
    bus.req_valid = '1;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 60 && gq.size() < 4; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) gq.push_back(bus.req_ready);
    end
    chk("arb_grant_count", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++) begin
`ifdef VMEM_ARB_FIXED_PRIO_EN
      chk($sformatf("arb_order_%0d", k), gq[k], 1);
`else
      chk($sformatf("arb_order_%0d", k), gq[k], 64'(1 << (k % NR)));
`endif
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);

    // Single stream: base 5, stride 2, data A..D.
    fill(4, 0, 0);
    for (int k = 0; k < 4; k++) el_data[k] = DW'(32'hA + k);
    run_stream(0, 5, 2, 4);
    chk("single_consecutive", (wr_cyc_q.size() >= 4) ? wr_cyc_q[3] - wr_cyc_q[0] : -1, 3);

    // Mask and stall on requester 1.
    fill(3, 0, 0);
    el_mask[1]  = 1'b0;
    el_stall[1] = 2;
    el_stall[2] = 2;
    run_stream(1, 40, 3, 3);
    chk("mask_stall_spacing", (wr_cyc_q.size() >= 2) ? wr_cyc_q[1] - wr_cyc_q[0] : -1, 6);

    // Address wrap-around.
    fill(3, 1, 0);
    run_stream(0, 1020, 3, 3);

    // Clamping and zero length.
    run_stream(1, 77, 4, 0);
    fill(32, 0, 0);
    run_stream(1, 900, 4, 40);
    fill(5, 0, 0);
    run_stream(0, 100, 20, 5);

    // Randomized streams.
    for (int n = 0; n < 8; n++) begin
      r      = $urandom_range(0, NR - 1);
      base   = $urandom_range(0, (1 << MD) - 1);
      stride = $urandom_range(0, 20);
      vl     = $urandom_range(0, 40);
      fill(32, 2, 1);
      run_stream(r, base, stride, vl);
    end

    // Reset mid-burst: requester 0 served last, requester 1 aborted after 2 of 8.
    run_stream(0, 10, 1, 0);
    fill(8, 0, 0);
    exp_q.push_back({MD'(200), el_data[0]});
    exp_q.push_back({MD'(205), el_data[1]});
    begin
      bit ok;
      issue(1, 200, 5, 8, ok);
      if (ok) feed(1, 2);
    end
    rst = 1'b1;
    dc0 = done_cnt;
    @(negedge clk);
    @(negedge clk);
    chk("abort_mem_w_en", bus.mem_w_en, 0);
    chk("abort_mem_addr", bus.mem_addr_write, 0);
    chk("abort_mem_data", bus.mem_data, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_data_ready", bus.data_ready, 0);
    chk("abort_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", done_cnt - dc0, 0);
    chk("abort_exp_drained", exp_q.size(), 0);

    @(posedge clk); #1;
    bus.req_vl    = '0;
    bus.req_valid = '1;
    gq.delete();
    for (int t = 0; t < 20 && gq.size() < 1; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) gq.push_back(bus.req_ready);
    end
    chk("post_reset_first_grant", (gq.size() > 0) ? gq[0] : 2'b00, 1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    for (int t = 0; t < 20 && gq.size() < 2; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) gq.push_back(bus.req_ready);
    end
    chk("post_reset_second_grant", (gq.size() > 1) ? gq[1] : 2'b00, 2);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
